// File: rtl/pwm_compare_pkg.sv
// rtl/pwm_compare_pkg.sv - shared widths for the PWM compare block
package pwm_compare_pkg;

    localparam int PERIOD_W  = 8;
    localparam int N_DEFAULT = 3;

endpackage : pwm_compare_pkg

// File: rtl/wrap_detect.sv
// rtl/wrap_detect.sv - period-start detection from the upstream counter
module wrap_detect
    import pwm_compare_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] counter,
    output logic         ps,
    output logic [N-1:0] prev
);

    logic [N-1:0] prev_q;

    // Remember last cycle's count; reset to all ones so the first zero after reset counts as a start.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prev_q <= '1;
        end else begin
            prev_q <= counter;
        end
    end

    // A period starts on the first cycle the count sits at zero, whether by natural wrap or upstream clear.
    always_comb begin
        ps = (counter == '0) && (prev_q != '0);
    end

    assign prev = prev_q;

endmodule : wrap_detect

// File: rtl/pwm_compare.sv
// rtl/pwm_compare.sv - double-buffered duty compare producing a registered PWM waveform
module pwm_compare
    import pwm_compare_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [N-1:0]        counter,
    input  logic                en,
    input  logic [N-1:0]        duty,
    input  logic                duty_we,
    output logic                pwm,
    output logic                wrap,
    output logic [N-1:0]        duty_active,
    output logic                pending,
    output logic [PERIOD_W-1:0] periods
);

    logic                ps;
    logic [N-1:0]        prev;

    logic                pwm_q, pwm_d;
    logic                wrap_q;
    logic [N-1:0]        active_q, active_d;
    logic [N-1:0]        shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] periods_q, periods_d;
    logic [N-1:0]        eff_duty;

    wrap_detect #(.N(N)) u_wrap_detect (
        .clk     (clk),
        .clr_n   (clr_n),
        .counter (counter),
        .ps      (ps),
        .prev    (prev)
    );

    // Next-state: the shadow is promoted at period start so the compare switches duty on the very first slot.
    always_comb begin
        eff_duty  = (ps && pending_q) ? shadow_q : active_q;
        pwm_d     = en && (counter < eff_duty);
        active_d  = eff_duty;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        periods_d = periods_q;
        if (duty_we) begin
            shadow_d  = duty;
            pending_d = 1'b1;
        end else if (ps) begin
            pending_d = 1'b0;
        end
        if (ps) begin
            periods_d = periods_q + 1'b1;
        end
    end

    // State registers; reset drops any unloaded shadow value.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pwm_q     <= 1'b0;
            wrap_q    <= 1'b0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            periods_q <= '0;
        end else begin
            pwm_q     <= pwm_d;
            wrap_q    <= ps;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            periods_q <= periods_d;
        end
    end

    // A period start can only follow a nonzero previous count.
    always @(posedge clk) begin
        if (clr_n && ps) begin
            assert (counter == '0 && prev != '0);
        end
    end

    assign pwm         = pwm_q;
    assign wrap        = wrap_q;
    assign duty_active = active_q;
    assign pending     = pending_q;
    assign periods     = periods_q;

endmodule : pwm_compare

// File: tb/tb_pwm_compare.sv
// tb/tb_pwm_compare.sv - self-checking bench for pwm_compare
module tb_pwm_compare;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         clr_n;
    logic [N-1:0] counter;
    logic         en;
    logic [N-1:0] duty;
    logic         duty_we;
    logic         pwm;
    logic         wrap;
    logic [N-1:0] duty_active;
    logic         pending;
    logic [7:0]   periods;

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_prev, m_shadow, m_active, m_periods;
    bit m_pending, m_pwm, m_wrap;

    pwm_compare #(.N(N)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .counter     (counter),
        .en          (en),
        .duty        (duty),
        .duty_we     (duty_we),
        .pwm         (pwm),
        .wrap        (wrap),
        .duty_active (duty_active),
        .pending     (pending),
        .periods     (periods)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 7; m_shadow = 0; m_active = 0; m_periods = 0;
        m_pending = 0; m_pwm = 0; m_wrap = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pwm"},     32'(pwm),         32'(m_pwm));
        check({tag, ".wrap"},    32'(wrap),        32'(m_wrap));
        check({tag, ".active"},  32'(duty_active), 32'(m_active));
        check({tag, ".pending"}, 32'(pending),     32'(m_pending));
        check({tag, ".periods"}, 32'(periods),     32'(m_periods));
    endtask

    // One clock: predict from the current inputs, clock, then compare.
    task automatic tick();
        int  c;
        bit  start;
        int  use_duty;
        c        = int'(counter);
        start    = (c == 0) && (m_prev != 0);
        use_duty = (start && m_pending) ? m_shadow : m_active;
        m_pwm    = en && (c < use_duty);
        m_wrap   = start;
        m_active = use_duty;
        if (duty_we) begin
            m_shadow  = int'(duty);
            m_pending = 1;
        end else if (start) begin
            m_pending = 0;
        end
        if (start) m_periods = (m_periods + 1) % 256;
        m_prev = c;
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic run(input int k);
        repeat (k) begin
            tick();
            counter = counter + 1'b1;
        end
    endtask

    task automatic write_duty(input int d);
        duty    = N'(d);
        duty_we = 1'b1;
        tick();
        duty_we = 1'b0;
        counter = counter + 1'b1;
    endtask

    // Runs one full period from counter 0, counting pwm-high slots and wrap pulses.
    task automatic measure(output int hi, output int w);
        hi = 0; w = 0;
        repeat (8) begin
            tick();
            hi += int'(pwm);
            w  += int'(wrap);
            counter = counter + 1'b1;
        end
    endtask

    task automatic async_reset();
        clr_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        int hi, w, per0, r, hold;
        clr_n = 1'b0; en = 1'b1; duty = '0; duty_we = 1'b0; counter = 3'd5;
        model_reset();
        #12;
        check_all("reset");
        clr_n = 1'b1;

        // Duty 3 waits in the shadow until the first period start.
        write_duty(3);
        check("dir.pending_before_ps", 32'(pending), 32'd1);
        run(2);
        tick();
        check("dir.active_after_ps", 32'(duty_active), 32'd3);
        check("dir.pending_after_ps", 32'(pending), 32'd0);
        check("dir.wrap_after_ps", 32'(wrap), 32'd1);
        counter = counter + 1'b1;
        run(7);
        measure(hi, w);
        check("dir.duty3_high", 32'(hi), 32'd3);

        // Upstream clear at 5 held three cycles.
        run(5);
        per0 = int'(periods);
        counter = '0;
        w = 0;
        repeat (3) begin
            tick();
            w += int'(wrap);
        end
        check("dir.clear_wraps", 32'(w), 32'd1);
        check("dir.clear_periods", 32'(periods), 32'((per0 + 1) % 256));
        counter = 3'd1;
        run(7);

        // Write coinciding with period start.
        run(3);
        write_duty(2);
        run(4);
        write_duty(6);
        check("dir.coincide_active", 32'(duty_active), 32'd2);
        check("dir.coincide_pending", 32'(pending), 32'd1);
        run(7);
        tick();
        check("dir.next_active", 32'(duty_active), 32'd6);
        counter = counter + 1'b1;
        run(7);

        // Duty extremes and enable off.
        write_duty(0);
        run(7);
        measure(hi, w);
        check("dir.duty0_high", 32'(hi), 32'd0);
        write_duty(7);
        run(7);
        measure(hi, w);
        check("dir.duty7_high", 32'(hi), 32'd7);
        en = 1'b0;
        per0 = int'(periods);
        measure(hi, w);
        check("dir.en0_high", 32'(hi), 32'd0);
        check("dir.en0_wrap", 32'(w), 32'd1);
        check("dir.en0_periods", 32'(periods), 32'((per0 + 1) % 256));
        en = 1'b1;

        // 256 periods wrap the period counter back.
        per0 = int'(periods);
        run(256 * 8);
        check("dir.periods_wrap", 32'(periods), 32'(per0));

        // Reset mid-period with a pending value.
        run(3);
        write_duty(5);
        check("dir.pending_pre_rst", 32'(pending), 32'd1);
        async_reset();
        run(4);
        tick();
        check("dir.post_rst_wrap", 32'(wrap), 32'd1);
        check("dir.post_rst_periods", 32'(periods), 32'd1);
        counter = counter + 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            en      = ($urandom % 8) != 0;
            duty    = N'($urandom);
            duty_we = ($urandom % 4) == 0;
            r       = int'($urandom_range(0, 39));
            if (r == 0) begin
                hold    = int'($urandom_range(1, 4));
                counter = '0;
                repeat (hold) tick();
                counter = 3'd1;
            end else if (r == 1) begin
                async_reset();
            end else begin
                tick();
                counter = counter + 1'b1;
            end
        end
        duty_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_compare
